// File: rtl/pixel_writer.sv
// Framebuffer pixel writer: converts Q16.16 RGB light values to packed 8-bit pixels and
// issues one memory write per pixel, scanning addresses row by row through the frame.
module pixel_writer #(
   parameter int unsigned H_RES     = 320,
   parameter int unsigned V_RES     = 240,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic             i_clk,
   input  logic             i_rstn,
   input  logic [0:2][31:0] i_light,
   input  logic             i_valid,
   output logic             o_busy,
   output logic [31:0]      o_addr,
   output logic [31:0]      o_wrdata,
   output logic             o_write,
   input  logic             i_waitrequest,
   output logic             o_frame_done
);

   localparam int unsigned XW = (H_RES > 1) ? $clog2(H_RES) : 1;
   localparam int unsigned YW = (V_RES > 1) ? $clog2(V_RES) : 1;

   typedef enum logic {StIdle, StWrite} state_e;

   state_e        state_q, state_d;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   data_q, data_d;
   logic          frame_done_q, frame_done_d;
   logic          accept, x_last, y_last;

   // Negative saturates to 0, anything at or above 1.0 saturates to 255.
   function automatic logic [7:0] conv(input logic [31:0] v);
      if (v[31]) begin
         return 8'h00;
      end else if (|v[30:16]) begin
         return 8'hff;
      end else begin
         return v[15:8];
      end
   endfunction

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (i_valid) state_d = StWrite;
         StWrite: if (!i_waitrequest) state_d = StIdle;
      endcase
   end

   always_comb begin
      o_busy  = (state_q == StWrite);
      o_write = (state_q == StWrite);
   end

   assign accept = (state_q == StWrite) && !i_waitrequest;
   assign x_last = (x_q == XW'(H_RES - 1));
   assign y_last = (y_q == YW'(V_RES - 1));

   // addr_q always holds the address of the current (x, y), so it is advanced in step with
   // the scan position instead of being recomputed from a multiply.
   always_comb begin
      x_d          = x_q;
      y_d          = y_q;
      addr_d       = addr_q;
      data_d       = data_q;
      frame_done_d = 1'b0;
      if ((state_q == StIdle) && i_valid) begin
         data_d = {8'h00, conv(i_light[0]), conv(i_light[1]), conv(i_light[2])};
      end
      if (accept) begin
         if (x_last) begin
            x_d = '0;
            if (y_last) begin
               y_d          = '0;
               addr_d       = BASE_ADDR;
               frame_done_d = 1'b1;
            end else begin
               y_d    = y_q + 1'b1;
               addr_d = addr_q + 32'd4;
            end
         end else begin
            x_d    = x_q + 1'b1;
            addr_d = addr_q + 32'd4;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         x_q          <= '0;
         y_q          <= '0;
         addr_q       <= BASE_ADDR;
         data_q       <= '0;
         frame_done_q <= 1'b0;
      end else begin
         x_q          <= x_d;
         y_q          <= y_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign o_addr       = addr_q;
   assign o_wrdata     = data_q;
   assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_pixel_writer.sv
// Scoreboard bench for pixel_writer on a 4x2 frame: stimulus pushes expected writes, a
// negedge monitor pops and compares each accepted write and checks frame_done pulses.
module tb_pixel_writer;

   localparam int unsigned H = 4;
   localparam int unsigned V = 2;
   localparam logic [31:0] BASE = 32'h0000_0100;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [0:2][31:0] light;
   logic             valid;
   logic             waitreq;
   logic             busy;
   logic [31:0]      addr;
   logic [31:0]      wrdata;
   logic             write;
   logic             frame_done;

   int          checks = 0;
   int          errors = 0;
   int          idx = 0;
   int          fd_count = 0;
   logic        fd_pend = 1'b0;
   logic [64:0] sb_q[$];
   logic [64:0] mon_e;

   pixel_writer #(
      .H_RES     (H),
      .V_RES     (V),
      .BASE_ADDR (BASE)
   ) dut (
      .i_clk         (clk),
      .i_rstn        (rst_n),
      .i_light       (light),
      .i_valid       (valid),
      .o_busy        (busy),
      .o_addr        (addr),
      .o_wrdata      (wrdata),
      .o_write       (write),
      .i_waitrequest (waitreq),
      .o_frame_done  (frame_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: an accepted write is o_write && !i_waitrequest at the coming rising edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         fd_pend = 1'b0;
      end else begin
         if (frame_done || fd_pend) check("frame_done", 32'(frame_done), 32'(fd_pend));
         if (frame_done) fd_count++;
         fd_pend = 1'b0;
         if (write && !waitreq) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: got addr %h data %h expected no write",
                        addr, wrdata);
            end else begin
               mon_e = sb_q.pop_front();
               check("wr_addr", addr, mon_e[63:32]);
               check("wr_data", wrdata, mon_e[31:0]);
               fd_pend = mon_e[64];
            end
         end
      end
   end

   task automatic push(input logic [31:0] exp_data);
      logic [31:0] a;
      a = BASE + 32'(4 * idx);
      sb_q.push_back({(idx == int'(H * V) - 1), a, exp_data});
      idx = (idx + 1) % int'(H * V);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (busy) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout: got busy=1 expected busy=0 within 50 cycles");
      end
   endtask

   task automatic send(input logic [0:2][31:0] lv, input logic [31:0] exp, input int nwait);
      logic [31:0] h_addr, h_data;
      wait_idle();
      light = lv;
      valid = 1'b1;
      push(exp);
      @(posedge clk);
      #1;
      valid = 1'b0;
      check("write_after_capture", 32'(write), 32'd1);
      check("busy_after_capture", 32'(busy), 32'd1);
      waitreq = (nwait > 0);
      h_addr = addr;
      h_data = wrdata;
      for (int i = 0; i < nwait; i++) begin
         @(posedge clk);
         #1;
         check("stall_write", 32'(write), 32'd1);
         check("stall_busy", 32'(busy), 32'd1);
         check("stall_addr", addr, h_addr);
         check("stall_data", wrdata, h_data);
      end
      waitreq = 1'b0;
      @(posedge clk);
      #1;
      check("idle_after_accept", 32'(busy), 32'd0);
      check("write_after_accept", 32'(write), 32'd0);
   endtask

   initial begin
      rst_n   = 1'b0;
      valid   = 1'b0;
      waitreq = 1'b0;
      light   = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_write", 32'(write), 32'd0);
      check("rst_addr", addr, BASE);
      check("rst_wrdata", wrdata, 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      rst_n = 1'b1;

      send({32'h0000_8000, 32'h0000_4000, 32'h0000_0100}, 32'h0080_4001, 0);
      send({32'hffff_0000, 32'h0001_0000, 32'h0000_ffff}, 32'h0000_ffff, 5);
      send({32'h0000_00ff, 32'h0000_ff00, 32'h8000_0000}, 32'h0000_ff00, 1);
      send({32'h0001_0000, 32'h0000_ffff, 32'h7fff_ffff}, 32'h00ff_ffff, 0);

      // Held valid: captures on odd edges, accepts on even edges; wraps the frame.
      wait_idle();
      light = {32'h0000_1234, 32'h0000_5678, 32'h0000_9abc};
      valid = 1'b1;
      for (int k = 0; k < 5; k++) push(32'h0012_569a);
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk);
         #1;
         check("busy_alternate", 32'(busy), 32'(k % 2));
      end
      valid = 1'b0;

      // Reset while stalled in WRITE: the pending write is dropped without a clock edge.
      wait_idle();
      light = {32'h0000_4400, 32'h0000_5500, 32'h0000_6600};
      valid = 1'b1;
      @(posedge clk);
      #1;
      valid   = 1'b0;
      waitreq = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      check("stalled_write", 32'(write), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_write_drop", 32'(write), 32'd0);
      check("async_busy_drop", 32'(busy), 32'd0);
      check("async_addr_base", addr, BASE);
      check("async_wrdata_clear", wrdata, 32'd0);
      idx = 0;
      #10;
      rst_n   = 1'b1;
      waitreq = 1'b0;

      send({32'h0000_ff00, 32'h0000_7f80, 32'h0000_0080}, 32'h00ff_7f00, 0);
      wait_idle();
      repeat (2) @(posedge clk);
      #1;
      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      check("frame_done_count", 32'(fd_count), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
